// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter driving the register file's single write port from two requesters.
// Define REGFILE_CLEAR_SEQ_EN to zero every register after reset before accepting traffic.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Hold,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_DR,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_DR,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    output logic              LD_REG,
    output logic [ADDR_W-1:0] DR_Out,
    output logic [DATA_W-1:0] BUS_Out,
    output logic              Busy,
    output logic              Grant_Id
);

    logic in_run;
    logic accept_en;
    logic ptr_q;

`ifdef REGFILE_CLEAR_SEQ_EN
    typedef enum logic {StClear, StRun} state_e;
    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;

    assign in_run = (state_q == StRun);
    assign Busy   = (state_q == StClear);
`else
    assign in_run = 1'b1;
    assign Busy   = 1'b0;
`endif

    // Reset gates Ready directly so requesters never see an accept while reset is held.
    assign accept_en  = in_run && !Hold && !Reset;
    assign Req0_Ready = accept_en && Req0_Valid && (!Req1_Valid || !ptr_q);
    assign Req1_Ready = accept_en && Req1_Valid && (!Req0_Valid || ptr_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
`ifdef REGFILE_CLEAR_SEQ_EN
            state_q   <= StClear;
            clr_cnt_q <= '0;
`endif
            ptr_q    <= 1'b0;
            LD_REG   <= 1'b0;
            DR_Out   <= '0;
            BUS_Out  <= '0;
            Grant_Id <= 1'b0;
        end else begin
`ifdef REGFILE_CLEAR_SEQ_EN
            if (state_q == StClear) begin
                LD_REG    <= 1'b1;
                DR_Out    <= clr_cnt_q;
                BUS_Out   <= '0;
                Grant_Id  <= 1'b0;
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_q <= StRun;
                end
            end else
`endif
            if (Req0_Ready || Req1_Ready) begin
                LD_REG   <= 1'b1;
                DR_Out   <= Req1_Ready ? Req1_DR : Req0_DR;
                BUS_Out  <= Req1_Ready ? Req1_Data : Req0_Data;
                Grant_Id <= Req1_Ready;
                ptr_q    <= !Req1_Ready;
            end else begin
                LD_REG <= 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the register file's single write port (LD_REG / DR / BUS) between two requesters, e.g. the CPU writeback path (req0) and a debug/load port (req1). Fair round-robin grants, a valid/ready handshake per requester, and one-cycle registered drive of the write port. An optional post-reset sequencer zeroes all eight registers before normal traffic is accepted.

## Interface
Parameters:
- DATA_W, 16, width of write data
- ADDR_W, 3, width of destination register index (8 registers)

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Hold  in  1  stall; while high no new grants are issued
- Req0_Valid  in  1  requester 0 has a write pending
- Req0_DR  in  ADDR_W  requester 0 destination register
- Req0_Data  in  DATA_W  requester 0 write data
- Req0_Ready  out  1  requester 0 accepted this cycle (combinational)
- Req1_Valid / Req1_DR / Req1_Data / Req1_Ready  same as req0, for requester 1
- LD_REG  out  1  write enable to register file (registered)
- DR_Out  out  ADDR_W  destination index to register file (registered)
- BUS_Out  out  DATA_W  write data to register file (registered)
- Busy  out  1  clear sequence in progress
- Grant_Id  out  1  requester that issued the current LD_REG write (registered)

## Operation
- States: CLEAR, RUN. Reset forces CLEAR (macro on) or RUN (macro off), clear counter = 0, priority pointer = 0.
- A transfer occurs on a cycle where ReqN_Valid && ReqN_Ready. At most one transfer per cycle.
- Ready rule in RUN with Hold = 0:
  - one Valid only: that requester's Ready = 1.
  - both Valid: Ready goes to the requester named by the priority pointer.
  - In CLEAR or with Hold = 1: both Ready = 0.
- Pointer update: after any transfer the pointer is set to the other requester. Idle cycles leave it unchanged.
- Write-port registers, updated every edge:
  - on a transfer: LD_REG <= 1, DR_Out <= DR, BUS_Out <= Data, Grant_Id <= granted index.
  - otherwise: LD_REG <= 0. DR_Out, BUS_Out and Grant_Id hold their values.
- Same-DR collisions need no special handling. Writes reach the register file in grant order, so the later grant wins.
- Requesters must hold Valid/DR/Data stable until accepted. The block does not buffer requests.
- CLEAR (macro on), once per edge:
  - LD_REG <= 1, DR_Out <= counter, BUS_Out <= 0, Grant_Id <= 0, counter++.
  - on the edge where counter == 7: state <= RUN.
- Busy = (state == CLEAR).

## Timing
- Reset values: LD_REG 0, DR_Out 0, BUS_Out 0, Grant_Id 0. Busy = 1 with the macro, 0 without. Ready outputs are 0 while Reset is high.
- Latency: a transfer accepted in cycle N produces LD_REG = 1 in cycle N+1. The register file captures the data at the end of cycle N+1.
- Throughput: one write per cycle. Back-to-back transfers keep LD_REG high continuously.
- Both requesters held valid: grants alternate every cycle, e.g. 0,1,0,1 with pointer 0 after reset.
- Clear: LD_REG is high for exactly 8 cycles after Reset deasserts, with DR_Out = 0..7 in order. Busy falls after the 8th edge. The first grant is possible in that same cycle, so its LD_REG follows the DR = 7 clear write with no gap.
- Hold rising during a cycle blocks that cycle's grant. A write already registered still completes.
- Reset asserted mid-clear or mid-traffic: all outputs go to reset values immediately. In-flight LD_REG is dropped, and the clear restarts from register 0.

## Configuration
- REGFILE_CLEAR_SEQ_EN defined:
  - reset enters CLEAR and the 8-cycle zeroing sequence runs.
  - Busy behaves as above.
- Not defined:
  - CLEAR state and counter are removed. Reset enters RUN directly.
  - Busy is tied to 0, and the first grant is possible in the first cycle after Reset deasserts.

## Test plan
- Reset release with REGFILE_CLEAR_SEQ_EN -> LD_REG = 1 for 8 cycles, DR_Out 0..7, BUS_Out 0x0000, Busy 1 then 0, both Ready 0 throughout.
- req0 alone, DR = 3, Data = 0x1234 -> Req0_Ready = 1 the same cycle. Next cycle LD_REG = 1, DR_Out = 3, BUS_Out = 0x1234, Grant_Id = 0.
- Both valid for 4 cycles (req0 DR = 1 / 0xAAAA, req1 DR = 2 / 0x5555) -> Grant_Id sequence 0,1,0,1, LD_REG high for 4 consecutive cycles.
- Both valid, both DR = 5, data 0x0001 / 0x0002 -> two writes to R5 in grant order; final R5 = 0x0002 when pointer starts at 0.
- Hold = 1 with both valid for 3 cycles -> both Ready 0, LD_REG 0. On Hold release, grants resume with the pointer unchanged.
- Reset pulsed at clear count 4 -> outputs reset immediately; after release, 8 full clear writes starting at DR 0.
